axi4_lite_rr_arbiter: RTL and testbench

AXI4_LITE_RR_ARBITER -- requirements
Module: axi4_lite_rr_arbiter

---
 rtl/axi4_lite_rr_arbiter_if.sv | 40 ++++
 rtl/axi4_lite_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi4_lite_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_rr_arbiter_if.sv
// Bus bundle for the two-requester AXI4-Lite arbiter: requester command/response
// lanes plus the command/completion port toward the AXI4-Lite master.
interface axi4_lite_rr_arbiter_if #(
   parameter int ADDRESS    = 32,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]              REQ_VALID;
   logic [1:0]              REQ_WRITE;
   logic [2*ADDRESS-1:0]    REQ_ADDR;
   logic [2*DATA_WIDTH-1:0] REQ_WDATA;
   logic [1:0]              REQ_READY;
   logic [1:0]              RSP_VALID;
   logic [DATA_WIDTH-1:0]   RSP_RDATA;
   logic                    RSP_ERR;
   logic                    M_CMD_VALID;
   logic                    M_CMD_READY;
   logic                    M_CMD_WRITE;
   logic [ADDRESS-1:0]      M_CMD_ADDR;
   logic [DATA_WIDTH-1:0]   M_CMD_WDATA;
   logic [3:0]              M_CMD_WSTRB;
   logic                    M_DONE;
   logic [DATA_WIDTH-1:0]   M_RDATA;
   logic                    M_RESP;
   logic                    BUSY;

   // Arbiter side: serves the requesters and drives the master command port.
   modport slave (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input  M_CMD_READY, M_DONE, M_RDATA, M_RESP,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      output M_CMD_VALID, M_CMD_WRITE, M_CMD_ADDR, M_CMD_WDATA, M_CMD_WSTRB, BUSY
   );

   modport master (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      output M_CMD_READY, M_DONE, M_RDATA, M_RESP,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      input  M_CMD_VALID, M_CMD_WRITE, M_CMD_ADDR, M_CMD_WDATA, M_CMD_WSTRB, BUSY
   );
endinterface

// File: rtl/axi4_lite_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI4-Lite master command
// port; one transaction in flight, aborted with an error after a bounded wait.
module axi4_lite_rr_arbiter #(
   parameter int ADDRESS        = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                   ACLK,
   input logic                   ARESETN,
   axi4_lite_rr_arbiter_if.slave bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state_r;
   logic                  last_grant_r;
   logic                  winner_r;
   logic                  write_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [1:0]            rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_rdata_r;
   logic                  rsp_err_r;
   logic                  cmd_valid_r;
   logic                  cmd_write_r;
   logic [ADDRESS-1:0]    cmd_addr_r;
   logic [DATA_WIDTH-1:0] cmd_wdata_r;
   logic [3:0]            cmd_wstrb_r;
   logic                  busy_r;

   logic                  pick_s;
   logic                  accept_s;
   logic [1:0]            ready_s;
   logic                  pick_write_s;
   logic [ADDRESS-1:0]    pick_addr_s;
   logic [DATA_WIDTH-1:0] pick_wdata_s;
   logic                  timeout_s;

   // Winner selection: the lone valid requester, or on a tie the one not served last
   always_comb begin
      if (bus.REQ_VALID == 2'b10) begin
         pick_s = 1'b1;
      end else if (bus.REQ_VALID == 2'b11) begin
         pick_s = ~last_grant_r;
      end else begin
         pick_s = 1'b0;
      end
      // READY is gated by ARESETN so nothing is granted while reset is held
      accept_s = ARESETN && (state_r == IDLE) && (bus.REQ_VALID != 2'b00);
      if (accept_s) begin
         ready_s = pick_s ? 2'b10 : 2'b01;
      end else begin
         ready_s = 2'b00;
      end
      pick_write_s = bus.REQ_WRITE[pick_s];
      if (pick_s) begin
         pick_addr_s  = bus.REQ_ADDR[2*ADDRESS-1:ADDRESS];
         pick_wdata_s = bus.REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
         pick_addr_s  = bus.REQ_ADDR[ADDRESS-1:0];
         pick_wdata_s = bus.REQ_WDATA[DATA_WIDTH-1:0];
      end
      timeout_s = (cnt_r == CNT_LAST);
   end

   assign bus.REQ_READY   = ready_s;
   assign bus.RSP_VALID   = rsp_valid_r;
   assign bus.RSP_RDATA   = rsp_rdata_r;
   assign bus.RSP_ERR     = rsp_err_r;
   assign bus.M_CMD_VALID = cmd_valid_r;
   assign bus.M_CMD_WRITE = cmd_write_r;
   assign bus.M_CMD_ADDR  = cmd_addr_r;
   assign bus.M_CMD_WDATA = cmd_wdata_r;
   assign bus.M_CMD_WSTRB = cmd_wstrb_r;
   assign bus.BUSY        = busy_r;

   // Transaction FSM with all outputs registered
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         winner_r     <= 1'b0;
         write_r      <= 1'b0;
         cnt_r        <= '0;
         rsp_valid_r  <= 2'b00;
         rsp_rdata_r  <= '0;
         rsp_err_r    <= 1'b0;
         cmd_valid_r  <= 1'b0;
         cmd_write_r  <= 1'b0;
         cmd_addr_r   <= '0;
         cmd_wdata_r  <= '0;
         cmd_wstrb_r  <= 4'h0;
         busy_r       <= 1'b0;
      end else begin
         rsp_valid_r <= 2'b00;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  winner_r    <= pick_s;
                  write_r     <= pick_write_s;
                  cmd_valid_r <= 1'b1;
                  cmd_write_r <= pick_write_s;
                  cmd_addr_r  <= pick_addr_s;
                  cmd_wdata_r <= pick_wdata_s;
                  cmd_wstrb_r <= 4'hF;
                  busy_r      <= 1'b1;
                  state_r     <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.M_CMD_READY) begin
                  cmd_valid_r <= 1'b0;
                  cmd_write_r <= 1'b0;
                  cmd_addr_r  <= '0;
                  cmd_wdata_r <= '0;
                  cmd_wstrb_r <= 4'h0;
                  cnt_r       <= '0;
                  state_r     <= WAIT;
               end
            end
            WAIT: begin
               // Completion takes priority over a timeout in the same cycle
               if (bus.M_DONE) begin
                  rsp_err_r   <= bus.M_RESP;
                  rsp_rdata_r <= write_r ? '0 : bus.M_RDATA;
                  rsp_valid_r <= winner_r ? 2'b10 : 2'b01;
                  state_r     <= RESP;
               end else if (timeout_s) begin
                  rsp_err_r   <= 1'b1;
                  rsp_rdata_r <= '0;
                  rsp_valid_r <= winner_r ? 2'b10 : 2'b01;
                  state_r     <= RESP;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            RESP: begin
               last_grant_r <= winner_r;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Directed bench for axi4_lite_rr_arbiter: a table of whole transactions with
// hand-computed results plus sequences for fairness, stray completions and reset.
module tb_axi4_lite_rr_arbiter;
   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  write;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] wdata0;
      logic [31:0] wdata1;
      int          ready_delay;
      int          done_delay;   // cycles after WAIT entry until M_DONE; -1 = never
      logic [31:0] m_rdata;
      logic        m_resp;
      logic [1:0]  exp_ready;
      logic        exp_write;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic aclk;
   logic aresetn;
   int   checks;
   int   errors;
   vec_t vecs [8];
   vec_t vr;
   vec_t vt;
   logic [1:0] fair_exp [4];
   int   ngrant;

   axi4_lite_rr_arbiter_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

   axi4_lite_rr_arbiter #(
      .ADDRESS(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .ACLK(aclk),
      .ARESETN(aresetn),
      .bus(bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/req_ready"}, bus.REQ_READY, 2'b00);
      check({tag, "/rsp_valid"}, bus.RSP_VALID, 2'b00);
      check({tag, "/rsp_rdata"}, bus.RSP_RDATA, 32'h0);
      check({tag, "/rsp_err"}, bus.RSP_ERR, 1'b0);
      check({tag, "/cmd_valid"}, bus.M_CMD_VALID, 1'b0);
      check({tag, "/cmd_write"}, bus.M_CMD_WRITE, 1'b0);
      check({tag, "/cmd_addr"}, bus.M_CMD_ADDR, 32'h0);
      check({tag, "/cmd_wdata"}, bus.M_CMD_WDATA, 32'h0);
      check({tag, "/cmd_wstrb"}, bus.M_CMD_WSTRB, 4'h0);
      check({tag, "/busy"}, bus.BUSY, 1'b0);
   endtask

   // One full transaction: request, ISSUE with optional backpressure, WAIT, RESP.
   task automatic run_vec(input vec_t v, input string tag);
      int n;
      int exp_lat;
      @(negedge aclk);
      bus.REQ_VALID   = v.valid;
      bus.REQ_WRITE   = v.write;
      bus.REQ_ADDR    = {v.addr1, v.addr0};
      bus.REQ_WDATA   = {v.wdata1, v.wdata0};
      bus.M_CMD_READY = 1'b0;
      bus.M_DONE      = 1'b0;
      #1;
      check({tag, "/req_ready"}, bus.REQ_READY, v.exp_ready);
      check({tag, "/idle_busy"}, bus.BUSY, 1'b0);
      for (int d = 0; d <= v.ready_delay; d++) begin
         @(negedge aclk);
         bus.REQ_VALID   = 2'b00;
         bus.M_CMD_READY = (d == v.ready_delay);
         bus.M_DONE      = 1'b1;       // stray completion while issuing
         bus.M_RESP      = 1'b1;
         bus.M_RDATA     = 32'h0BAD_0BAD;
         #1;
         check({tag, "/cmd_valid"}, bus.M_CMD_VALID, 1'b1);
         check({tag, "/cmd_write"}, bus.M_CMD_WRITE, v.exp_write);
         check({tag, "/cmd_addr"}, bus.M_CMD_ADDR, v.exp_addr);
         check({tag, "/cmd_wdata"}, bus.M_CMD_WDATA, v.exp_wdata);
         check({tag, "/cmd_wstrb"}, bus.M_CMD_WSTRB, 4'hF);
         check({tag, "/issue_rsp"}, bus.RSP_VALID, 2'b00);
      end
      @(negedge aclk);
      n               = 0;
      bus.M_CMD_READY = 1'b0;
      bus.M_DONE      = (v.done_delay == 0);
      bus.M_RESP      = v.m_resp;
      bus.M_RDATA     = v.m_rdata;
      #1;
      check({tag, "/wait_cmd_valid"}, bus.M_CMD_VALID, 1'b0);
      check({tag, "/wait_cmd_addr"}, bus.M_CMD_ADDR, 32'h0);
      check({tag, "/wait_cmd_wdata"}, bus.M_CMD_WDATA, 32'h0);
      check({tag, "/wait_busy"}, bus.BUSY, 1'b1);
      while (bus.RSP_VALID == 2'b00 && n < 20) begin
         @(negedge aclk);
         n++;
         bus.M_DONE = (v.done_delay >= 0) && (n == v.done_delay || n == v.done_delay + 1);
         #1;
      end
      exp_lat = (v.done_delay < 0) ? 8 : v.done_delay + 1;
      check({tag, "/latency"}, n, exp_lat);
      check({tag, "/rsp_valid"}, bus.RSP_VALID, v.exp_ready);
      check({tag, "/rsp_rdata"}, bus.RSP_RDATA, v.exp_rdata);
      check({tag, "/rsp_err"}, bus.RSP_ERR, v.exp_err);
      @(negedge aclk);
      bus.M_DONE = 1'b0;
      #1;
      check({tag, "/rsp_pulse"}, bus.RSP_VALID, 2'b00);
      check({tag, "/end_busy"}, bus.BUSY, 1'b0);
      check({tag, "/hold_rdata"}, bus.RSP_RDATA, v.exp_rdata);
      check({tag, "/hold_err"}, bus.RSP_ERR, v.exp_err);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //              valid  write  addr0     addr1     wdata0        wdata1        rdy dn  m_rdata       resp  ready  wr    addr      wdata         rdata         err
      vecs[0] = '{2'b01, 2'b00, 32'h10,  32'h0,   32'h1111_1111, 32'h2222_2222, 0, 1,  32'hDEAD_BEEF, 1'b0, 2'b01, 1'b0, 32'h10,  32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{2'b10, 2'b10, 32'h0,   32'h20,  32'h0,         32'h5A,        0, 0,  32'hCAFE_F00D, 1'b1, 2'b10, 1'b1, 32'h20,  32'h5A,        32'h0,         1'b1};
      vecs[2] = '{2'b11, 2'b01, 32'h100, 32'h200, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 0, 0,  32'h1234_5678, 1'b0, 2'b01, 1'b1, 32'h100, 32'hA0A0_A0A0, 32'h0,         1'b0};
      vecs[3] = '{2'b11, 2'b01, 32'h100, 32'h200, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 5, 2,  32'h0BAD_F00D, 1'b0, 2'b10, 1'b0, 32'h200, 32'hB1B1_B1B1, 32'h0BAD_F00D, 1'b0};
      vecs[4] = '{2'b01, 2'b00, 32'h40,  32'h0,   32'h0,         32'h0,         0, -1, 32'hFFFF_FFFF, 1'b0, 2'b01, 1'b0, 32'h40,  32'h0,         32'h0,         1'b1};
      vecs[5] = '{2'b10, 2'b00, 32'h0,   32'h44,  32'h0,         32'h33,        0, 0,  32'h55AA_55AA, 1'b0, 2'b10, 1'b0, 32'h44,  32'h33,        32'h55AA_55AA, 1'b0};
      vecs[6] = '{2'b01, 2'b00, 32'h48,  32'h0,   32'h7,         32'h0,         0, 7,  32'h7777_7777, 1'b0, 2'b01, 1'b0, 32'h48,  32'h7,         32'h7777_7777, 1'b0};
      vecs[7] = '{2'b11, 2'b01, 32'h50,  32'h300, 32'h1,         32'h2,         1, 6,  32'h9999_9999, 1'b1, 2'b10, 1'b0, 32'h300, 32'h2,         32'h9999_9999, 1'b1};
      vr      = '{2'b01, 2'b00, 32'h60,  32'h0,   32'h0,         32'h0,         0, 0,  32'h600D_CAFE, 1'b0, 2'b01, 1'b0, 32'h60,  32'h0,         32'h600D_CAFE, 1'b0};
      vt      = '{2'b11, 2'b00, 32'h70,  32'h74,  32'h0,         32'h0,         0, 0,  32'h7070_7070, 1'b0, 2'b01, 1'b0, 32'h70,  32'h0,         32'h7070_7070, 1'b0};
      fair_exp[0] = 2'b01;
      fair_exp[1] = 2'b10;
      fair_exp[2] = 2'b01;
      fair_exp[3] = 2'b10;

      aresetn         = 1'b0;
      bus.REQ_VALID   = 2'b11;
      bus.REQ_WRITE   = 2'b00;
      bus.REQ_ADDR    = 64'h0;
      bus.REQ_WDATA   = 64'h0;
      bus.M_CMD_READY = 1'b0;
      bus.M_DONE      = 1'b0;
      bus.M_RDATA     = 32'h0;
      bus.M_RESP      = 1'b0;
      #12;
      check_all_zero("reset");
      bus.REQ_VALID = 2'b00;
      @(negedge aclk);
      aresetn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Stray completion in IDLE: no response, response fields hold
      @(negedge aclk);
      bus.M_DONE  = 1'b1;
      bus.M_RESP  = 1'b0;
      bus.M_RDATA = 32'h1313_1313;
      @(negedge aclk);
      bus.M_DONE = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stray/rsp_valid", bus.RSP_VALID, 2'b00);
         check("stray/busy", bus.BUSY, 1'b0);
         check("stray/rdata", bus.RSP_RDATA, 32'h9999_9999);
         check("stray/err", bus.RSP_ERR, 1'b1);
         @(negedge aclk);
      end

      // Both requesters held valid across four transactions
      bus.REQ_VALID   = 2'b11;
      bus.REQ_WRITE   = 2'b00;
      bus.M_CMD_READY = 1'b1;
      bus.M_DONE      = 1'b1;
      bus.M_RDATA     = 32'h0;
      ngrant          = 0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge aclk);
         #1;
         if (bus.REQ_READY != 2'b00) begin
            if (ngrant < 4) check($sformatf("fair/grant%0d", ngrant), bus.REQ_READY, fair_exp[ngrant]);
            ngrant++;
         end
      end
      check("fair/count", ngrant, 4);
      @(negedge aclk);
      bus.REQ_VALID   = 2'b00;
      bus.M_CMD_READY = 1'b0;
      bus.M_DONE      = 1'b0;
      #1;
      check("fair/end_busy", bus.BUSY, 1'b0);

      // Reset in the middle of WAIT, after requester 0 was served last
      run_vec(vr, "rst_pre");
      @(negedge aclk);
      bus.REQ_VALID = 2'b01;
      bus.REQ_ADDR  = {32'h0, 32'h64};
      #1;
      check("rst/accept", bus.REQ_READY, 2'b01);
      @(negedge aclk);
      bus.REQ_VALID   = 2'b00;
      bus.M_CMD_READY = 1'b1;
      @(negedge aclk);
      bus.M_CMD_READY = 1'b0;
      bus.REQ_VALID   = 2'b10;
      #1;
      check("rst/held_off", bus.REQ_READY, 2'b00);
      check("rst/wait_busy", bus.BUSY, 1'b1);
      @(negedge aclk);
      #1;
      check("rst/held_off2", bus.REQ_READY, 2'b00);
      #2;
      aresetn = 1'b0;
      #1;
      check_all_zero("rst_mid");
      bus.REQ_VALID = 2'b00;
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         #1;
         check("rst/no_grant_busy", bus.BUSY, 1'b0);
         check("rst/no_grant_cmd", bus.M_CMD_VALID, 1'b0);
      end
      run_vec(vt, "rst_tie");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
